// File: rtl/tlb_pkg.sv
// Shared definitions for the INVTLB sequencer: invtlb op encodings, page sizes
// and the sequencer state encoding.
package tlb_pkg;

  localparam logic [4:0] INVTLB_ALL0       = 5'd0;
  localparam logic [4:0] INVTLB_ALL1       = 5'd1;
  localparam logic [4:0] INVTLB_G1         = 5'd2;
  localparam logic [4:0] INVTLB_G0         = 5'd3;
  localparam logic [4:0] INVTLB_G0_ASID    = 5'd4;
  localparam logic [4:0] INVTLB_G0_ASID_VA = 5'd5;
  localparam logic [4:0] INVTLB_GASID_VA   = 5'd6;

  localparam logic [5:0] PS_4KB = 6'd12;
  localparam logic [5:0] PS_4MB = 6'd22;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WALK = 2'd1,
    ST_FIN  = 2'd2
  } state_e;

  // Ops above GASID_VA are reserved and complete immediately with err set.
  function automatic logic op_legal(input logic [4:0] op);
    return op <= INVTLB_GASID_VA;
  endfunction

endpackage

// File: rtl/tlb_inv_match.sv
// Combinational invtlb match: decides whether one TLB entry (as presented by
// the read port) is selected by the latched op/asid/vppn.
module tlb_inv_match
  import tlb_pkg::*;
(
  input  logic [4:0]  op,
  input  logic [9:0]  asid,
  input  logic [18:0] vppn,
  input  logic [18:0] r_vppn,
  input  logic [5:0]  r_ps,
  input  logic [9:0]  r_asid,
  input  logic        r_g,
  output logic        opmatch
);

  logic vam;
  logic asm;

  // A 4MB page ignores the low ten vppn bits when comparing addresses.
  assign vam = (vppn[18:10] == r_vppn[18:10]) &&
               ((r_ps == PS_4MB) || (vppn[9:0] == r_vppn[9:0]));
  assign asm = (asid == r_asid);

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case can leave it unassigned and infer a latch.
    opmatch = 1'b0;
    case (op)
      INVTLB_ALL0,
      INVTLB_ALL1:       opmatch = 1'b1;
      INVTLB_G1:         opmatch = r_g;
      INVTLB_G0:         opmatch = !r_g;
      INVTLB_G0_ASID:    opmatch = !r_g && asm;
      INVTLB_G0_ASID_VA: opmatch = !r_g && asm && vam;
      INVTLB_GASID_VA:   opmatch = (r_g || asm) && vam;
      default:           opmatch = 1'b0;
    endcase
  end

endmodule

// File: rtl/tlb_inv_ctrl.sv
// INVTLB sequencer: walks every TLB entry once per cycle, clears E on matching
// entries, and shares the single TLB write port with the TLBWR/TLBFILL path.
module tlb_inv_ctrl
  import tlb_pkg::*;
#(
  parameter  int TLBNUM = 16,
  localparam int IW     = $clog2(TLBNUM)
) (
  input  logic          clk,
  input  logic          resetn,

  input  logic          req_valid,
  output logic          req_ready,
  input  logic [4:0]    req_op,
  input  logic [9:0]    req_asid,
  input  logic [18:0]   req_vppn,
  output logic          done,
  output logic          err,
  output logic          busy,

  input  logic          ext_we,
  input  logic [IW-1:0] ext_index,
  input  logic          ext_e,
  output logic          ext_ready,

  output logic [IW-1:0] tlb_r_index,
  input  logic          tlb_r_e,
  input  logic [18:0]   tlb_r_vppn,
  input  logic [5:0]    tlb_r_ps,
  input  logic [9:0]    tlb_r_asid,
  input  logic          tlb_r_g,

  output logic          tlb_we,
  output logic [IW-1:0] tlb_w_index,
  output logic          tlb_w_e,
  output logic          tlb_w_sel
);

  localparam logic [IW-1:0] LAST_IDX = IW'(TLBNUM - 1);

  state_e        state, state_d;
  logic [IW-1:0] cnt, cnt_d;
  logic          err_q, err_d;
  logic [4:0]    op_q;
  logic [9:0]    asid_q;
  logic [18:0]   vppn_q;
  logic          latch_req;
  logic          opmatch;
  logic          hit;

  tlb_inv_match u_match (
    .op      (op_q),
    .asid    (asid_q),
    .vppn    (vppn_q),
    .r_vppn  (tlb_r_vppn),
    .r_ps    (tlb_r_ps),
    .r_asid  (tlb_r_asid),
    .r_g     (tlb_r_g),
    .opmatch (opmatch)
  );

  assign hit  = tlb_r_e && opmatch;
  assign busy = (state != ST_IDLE);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      err_q  <= 1'b0;
      op_q   <= '0;
      asid_q <= '0;
      vppn_q <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      state <= state_d;
      cnt   <= cnt_d;
      err_q <= err_d;
      if (latch_req) begin
        op_q   <= req_op;
        asid_q <= req_asid;
        vppn_q <= req_vppn;
      end
    end
  end

  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    err_d       = err_q;
    latch_req   = 1'b0;
    req_ready   = 1'b0;
    ext_ready   = 1'b0;
    done        = 1'b0;
    err         = 1'b0;
    tlb_r_index = '0;
    tlb_we      = 1'b0;
    tlb_w_index = '0;
    tlb_w_e     = 1'b0;
    tlb_w_sel   = 1'b0;

    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        ext_ready = 1'b1;
        // The external write lands on this edge, ahead of any walk started
        // by the same edge, so the walk sees the updated entry.
        tlb_we      = ext_we;
        tlb_w_index = ext_index;
        tlb_w_e     = ext_e;
        if (req_valid) begin
          latch_req = 1'b1;
          if (op_legal(req_op)) begin
            state_d = ST_WALK;
            cnt_d   = '0;
          end else begin
            state_d = ST_FIN;
            err_d   = 1'b1;
          end
        end
      end

      ST_WALK: begin
        tlb_r_index = cnt;
        if (hit) begin
          // Only E changes; the other fields come back from the read port.
          tlb_we      = 1'b1;
          tlb_w_index = cnt;
          tlb_w_e     = 1'b0;
          tlb_w_sel   = 1'b1;
        end
        cnt_d = cnt + IW'(1);
        if (cnt == LAST_IDX) begin
          state_d = ST_FIN;
        end
      end

      ST_FIN: begin
        done    = 1'b1;
        err     = err_q;
        err_d   = 1'b0;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: doc/tlb_inv_ctrl.md
Name: tlb_inv_ctrl

Overview:
Sequencer that executes LoongArch INVTLB over the TLB array by walking every entry, one per cycle, through the TLB read port and clearing E through the TLB write port. It also arbitrates the single TLB write port between itself and the TLBWR/TLBFILL path from the EXE/WB stage. The pipeline holds the INVTLB instruction, stalling on req_ready, until done.

Parameters:
TLBNUM, 16, number of TLB entries; power of two, at least 2.
IW, $clog2(TLBNUM), index width (derived, not overridable).

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
req_valid  in  1  INVTLB request
req_ready  out  1  request accepted this cycle when req_valid && req_ready
req_op  in  5  invtlb op field
req_asid  in  10  rj[9:0]
req_vppn  in  19  rk[31:13]
done  out  1  one-cycle completion pulse
err  out  1  valid with done; 1 means op > 6 and nothing was invalidated
busy  out  1  walk in progress (state != IDLE)
ext_we  in  1  TLBWR/TLBFILL write request
ext_index  in  IW  TLBWR/TLBFILL target index
ext_e  in  1  E bit for the external write
ext_ready  out  1  external write is performed this cycle
tlb_r_index  out  IW  to TLB read port
tlb_r_e  in  1  from TLB read port
tlb_r_vppn  in  19  from TLB read port
tlb_r_ps  in  6  from TLB read port; 12 or 22
tlb_r_asid  in  10  from TLB read port
tlb_r_g  in  1  from TLB read port
tlb_we  out  1  TLB write enable
tlb_w_index  out  IW  TLB write index
tlb_w_e  out  1  TLB write E bit
tlb_w_sel  out  1  payload source for the top-level mux: 0 = CSR payload, 1 = TLB read-port data

Behaviour:
- Clocking and reset: single clock domain. Reset is asynchronous, active-low. Reset forces IDLE, cnt=0, and all outputs to 0 except req_ready=1 and ext_ready=1.
- States: IDLE, WALK, FIN.
- IDLE:
  - req_ready=1; ext_ready=1.
  - req_valid accepted: latch op, asid, vppn.
  - Accepted op <= 6: go to WALK with cnt=0.
  - Accepted op > 6: go to FIN with err_q=1.
- WALK:
  - tlb_r_index=cnt. Read is combinational, so tlb_r_* describe entry cnt in the same cycle.
  - hit = tlb_r_e && opmatch.
  - On hit: tlb_we=1, tlb_w_index=cnt, tlb_w_e=0, tlb_w_sel=1. All other fields are rewritten with their read-back values.
  - No write when hit=0.
  - cnt increments each cycle. When cnt==TLBNUM-1, go to FIN and wrap cnt to 0.
- FIN: done=1 and err=err_q for exactly one cycle, then return to IDLE and clear err_q. req_ready=0 in FIN.
- opmatch definitions:
  - vam = (vppn[18:10]==r_vppn[18:10]) && (r_ps==22 || vppn[9:0]==r_vppn[9:0]).
  - asm = (asid==r_asid).
  - op 0, 1: always.
  - op 2: g.
  - op 3: !g.
  - op 4: !g && asm.
  - op 5: !g && asm && vam.
  - op 6: (g || asm) && vam.
- Latency: request accepted at edge T gives WALK cycles T+1..T+TLBNUM, and done is high in cycle T+TLBNUM+1. An illegal op gives done in cycle T+1.
- Write arbitration:
  - In IDLE: tlb_we=ext_we, tlb_w_index=ext_index, tlb_w_e=ext_e, tlb_w_sel=0.
  - In WALK/FIN: ext_ready=0 and external writes are blocked. The requester holds ext_we until ext_ready.
- Simultaneous req_valid and ext_we in IDLE: both are accepted that cycle. The external write lands at edge T, so the walk observes the updated entry.
- Back-to-back requests: a new req_valid is only accepted in IDLE, i.e. one cycle after done.
- req_valid deasserted mid-walk: ignored; the walk completes.
- Reset mid-walk: immediate abort to IDLE. Entries already cleared stay cleared; no done pulse.
- tlb_r_index=0 whenever not in WALK.

Decomposition:
- Shared package tlb_pkg: op encodings INVTLB_ALL0=0, ALL1=1, G1=2, G0=3, G0_ASID=4, G0_ASID_VA=5, GASID_VA=6; PS_4KB=12, PS_4MB=22; state encoding.
- One natural sub-module: tlb_inv_match, purely combinational, computing opmatch from the latched op/asid/vppn and tlb_r_*. It is reused by the bench's reference model.

Test Plan:
- Fill all 16 entries with E=1, mixed G; issue op=0 -> 16 consecutive we pulses at indices 0..15 with w_e=0; done at T+17 with err=0; all r_e=0 afterwards.
- Entries 3 (G=1) and 7 (G=0, asid=5); issue op=2 -> only index 3 written; entry 7 keeps E=1.
- Op=5, asid=5, vppn=0x12345; entry 4 has asid=5, G=0, vppn=0x12345, ps=12; entry 9 identical but vppn=0x12346 -> only index 4 cleared. Repeat with entry 9 ps=22 and matching vppn[18:10] -> index 9 also cleared.
- Op=7 -> done and err=1 one cycle after accept; no tlb_we.
- ext_we at index 2 in the same cycle as op=3 accept -> external write occurs at T. ext_we at index 2 during WALK -> ext_ready=0 until the cycle after done, then the write is performed.
- resetn low at walk cycle 8 -> IDLE immediately; entries 0..7 cleared, 8..15 intact; no done; req_ready=1.
